// File: rtl/tapa_stream_pkg.sv
// Shared stream word definitions used by the FIFO and by its producers and consumers.
package tapa_stream_pkg;

    localparam int STREAM_DATA_WIDTH = 32;
    localparam int STREAM_WORD_WIDTH = STREAM_DATA_WIDTH + 1;

    // The MSB (eot) marks the close token that ends a transfer.
    typedef struct packed {
        logic                         eot;
        logic [STREAM_DATA_WIDTH-1:0] data;
    } stream_word_t;

    function automatic logic is_close_token(input stream_word_t w);
        return w.eot;
    endfunction

endpackage

// File: rtl/stream_fifo_peek_if.sv
// Producer/consumer/peek signal bundle of the stream FIFO.
interface stream_fifo_peek_if
    import tapa_stream_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_WORD_WIDTH,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);

    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] peek_dout;
    logic                  peek_empty_n;
    logic                  peek_read;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    // Producer/consumer side of the FIFO.
    modport master (
        output if_din, if_write, if_read, peek_read,
        input  if_full_n, if_dout, if_empty_n, peek_dout, peek_empty_n,
               count, overflow, underflow
    );

    // The FIFO itself.
    modport slave (
        input  if_din, if_write, if_read, peek_read,
        output if_full_n, if_dout, if_empty_n, peek_dout, peek_empty_n,
               count, overflow, underflow
    );

endinterface

// File: rtl/stream_fifo_mem.sv
// Simple dual-port storage: synchronous write, synchronous enabled read.
module stream_fifo_mem #(
    parameter int DATA_WIDTH = 33,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Store the incoming word at the write pointer.
    // NOTE: the array has no reset so it maps onto RAM; stale contents are never exposed because the pointers and output register are reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Load the read register only when the head advances, so it holds otherwise.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/stream_fifo_peek.sv
// Show-ahead stream FIFO with registered flags, occupancy count, sticky error bits and a peek view.
module stream_fifo_peek
    import tapa_stream_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_WORD_WIDTH,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    stream_fifo_peek_if.slave s_if
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full_n;
    logic                  r_empty_n;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_byp_sel;
    logic [DATA_WIDTH-1:0] r_byp_data;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_load;
    logic                  w_byp_hit;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DATA_WIDTH-1:0] w_mem_q;
    logic [DATA_WIDTH-1:0] w_dout;
    logic                  w_unused_peek_read;

    assign w_wr_en = s_if.if_write & r_full_n;
    assign w_rd_en = s_if.if_read & r_empty_n;

    // peek_read is deliberately ignored: peeking never pops.
    assign w_unused_peek_read = s_if.peek_read;

    // Next occupancy from the accepted handshakes.
    // NOTE: always_comb assigns a default first so no path leaves the output unassigned (no latch).
    always_comb begin
        w_count_next = r_count;
        if (w_wr_en && !w_rd_en) begin
            w_count_next = r_count + CNT_ONE;
        end else if (!w_wr_en && w_rd_en) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    // The head changes when a pop leaves words behind, or a write lands in an empty FIFO.
    assign w_load    = (w_rd_en && (w_count_next != '0)) || (w_wr_en && (r_count == '0));
    assign w_raddr   = w_rd_en ? (r_rptr + PTR_ONE) : r_rptr;
    // The new head is the word being written this very cycle: the array read would be stale.
    assign w_byp_hit = w_wr_en && (w_raddr == r_wptr);

    stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_wr_en (w_wr_en),
        .i_waddr (r_wptr),
        .i_wdata (s_if.if_din),
        .i_rd_en (w_load),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_q)
    );

    // Pointers, occupancy, registered flags and sticky error bits.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_full_n    <= 1'b0;
            r_empty_n   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count   <= w_count_next;
            r_full_n  <= (w_count_next < CNT_DEPTH);
            r_empty_n <= (w_count_next != '0);
            if (s_if.if_write && !r_full_n) begin
                r_overflow <= 1'b1;
            end
            if (s_if.if_read && !r_empty_n) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Bypass register: captures the written word when it becomes head in the same cycle.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
        end else if (w_load) begin
            r_byp_sel  <= w_byp_hit;
            r_byp_data <= s_if.if_din;
        end
    end

    // Both mux inputs and the select are registers, so no input reaches an output combinationally.
    assign w_dout = r_byp_sel ? r_byp_data : w_mem_q;

    assign s_if.if_dout      = w_dout;
    assign s_if.if_empty_n   = r_empty_n;
    assign s_if.if_full_n    = r_full_n;
    assign s_if.peek_dout    = w_dout;
    assign s_if.peek_empty_n = r_empty_n;
    assign s_if.count        = r_count;
    assign s_if.overflow     = r_overflow;
    assign s_if.underflow    = r_underflow;

endmodule

// File: tb/tb_stream_fifo_peek.sv
// Self-checking bench: directed steps with random data against a queue-based reference model.
module tb_stream_fifo_peek;
    import tapa_stream_pkg::*;

    localparam int DW    = 33;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;

    stream_fifo_peek_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) s_if ();

    stream_fifo_peek #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_if     (s_if)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue contents plus the visible registered flags.
    logic [DW-1:0] m_q[$];
    bit            m_full_n  = 1'b0;
    bit            m_empty_n = 1'b0;
    bit            m_ovf     = 1'b0;
    bit            m_unf     = 1'b0;
    logic [DW-1:0] m_dout    = '0;

    // Words the DUT presented on if_dout at each accepted pop.
    logic [DW-1:0] dut_popped[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [DW-1:0] din, input bit wr, input bit rd, input bit rst_n);
        bit acc_wr;
        bit acc_rd;
        if (!rst_n) begin
            m_q.delete();
            m_full_n  = 1'b0;
            m_empty_n = 1'b0;
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
            m_dout    = '0;
        end else begin
            acc_wr = wr && m_full_n;
            acc_rd = rd && m_empty_n;
            if (wr && !m_full_n) m_ovf = 1'b1;
            if (rd && !m_empty_n) m_unf = 1'b1;
            if (acc_rd) void'(m_q.pop_front());
            if (acc_wr) m_q.push_back(din);
            m_full_n  = (m_q.size() < DEPTH);
            m_empty_n = (m_q.size() != 0);
            if (m_q.size() != 0) m_dout = m_q[0];
        end
    endtask

    task automatic check_all();
        check("count",        64'(s_if.count),        64'(m_q.size()));
        check("empty_n",      64'(s_if.if_empty_n),   64'(m_empty_n));
        check("full_n",       64'(s_if.if_full_n),    64'(m_full_n));
        check("dout",         64'(s_if.if_dout),      64'(m_dout));
        check("peek_dout",    64'(s_if.peek_dout),    64'(m_dout));
        check("peek_empty_n", 64'(s_if.peek_empty_n), 64'(m_empty_n));
        check("overflow",     64'(s_if.overflow),     64'(m_ovf));
        check("underflow",    64'(s_if.underflow),    64'(m_unf));
    endtask

    // One clock: drive inputs, record DUT pops, advance the model, check #1 after the edge.
    task automatic tick(input logic [DW-1:0] din, input bit wr, input bit rd, input bit pk, input bit rst_n);
        s_if.if_din    = din;
        s_if.if_write  = wr;
        s_if.if_read   = rd;
        s_if.peek_read = pk;
        ap_rst_n       = rst_n;
        @(posedge ap_clk);
        if (rd && rst_n && s_if.if_empty_n) dut_popped.push_back(s_if.if_dout);
        model_edge(din, wr, rd, rst_n);
        #1;
        check_all();
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = {1'($urandom()), $urandom()};
        return w;
    endfunction

    initial begin
        logic [DW-1:0] stream_words[6];
        logic [DW-1:0] exp_seq[$];
        logic [DW-1:0] hold;
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
        int            idx;

        s_if.if_din    = '0;
        s_if.if_write  = 1'b0;
        s_if.if_read   = 1'b0;
        s_if.peek_read = 1'b0;

        // Reset held for 10 cycles, then released.
        for (int k = 0; k < 10; k++) tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_full_n",  64'(s_if.if_full_n),  64'd0);
        check("rst_empty_n", 64'(s_if.if_empty_n), 64'd0);
        check("rst_count",   64'(s_if.count),      64'd0);
        check("rst_dout",    64'(s_if.if_dout),    64'd0);
        tick('0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("release_full_n", 64'(s_if.if_full_n), 64'd1);

        // Single word with one-cycle write-to-readable latency.
        tick({1'b0, 32'h3F80_0000}, 1'b1, 1'b0, 1'b0, 1'b1);
        check("single_empty_n", 64'(s_if.if_empty_n), 64'd1);
        check("single_dout",    64'(s_if.if_dout),    64'h0_3F80_0000);
        check("single_peek",    64'(s_if.peek_dout),  64'h0_3F80_0000);
        tick('0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("single_pop_empty_n", 64'(s_if.if_empty_n), 64'd0);
        check("single_pop_count",   64'(s_if.count),      64'd0);

        // Float stream ending in a close token, consumer with random gaps.
        stream_words[0] = {1'b0, 32'h0000_0000};
        stream_words[1] = {1'b0, 32'h3F80_0000};
        stream_words[2] = {1'b0, 32'h4000_0000};
        stream_words[3] = {1'b0, 32'h4040_0000};
        stream_words[4] = {1'b0, 32'h4080_0000};
        stream_words[5] = {1'b1, 32'h0000_0000};
        dut_popped.delete();
        idx = 0;
        for (int k = 0; k < 200 && (idx < 6 || m_q.size() != 0); k++) begin
            if (idx < 6) begin
                tick(stream_words[idx], 1'b1, ($urandom_range(0, 2) != 0), 1'b0, 1'b1);
                idx++;
            end else begin
                tick('0, 1'b0, ($urandom_range(0, 2) != 0), 1'b0, 1'b1);
            end
        end
        check("stream_len", 64'(dut_popped.size()), 64'd6);
        for (int i = 0; i < 6 && i < dut_popped.size(); i++) begin
            check($sformatf("stream_word%0d", i), 64'(dut_popped[i]), 64'(stream_words[i]));
        end
        if (dut_popped.size() == 6) begin
            check("stream_close", 64'(is_close_token(stream_word_t'(dut_popped[5]))), 64'd1);
        end

        // Fill past capacity with no reads.
        dut_popped.delete();
        for (int i = 0; i < 33; i++) begin
            tick(DW'(100 + i), 1'b1, 1'b0, 1'b0, 1'b1);
            if (i == 31) begin
                check("full_count",  64'(s_if.count),     64'd32);
                check("full_full_n", 64'(s_if.if_full_n), 64'd0);
                check("full_ovf_pre", 64'(s_if.overflow), 64'd0);
            end
        end
        check("ovf_set",     64'(s_if.overflow), 64'd1);
        check("ovf_count",   64'(s_if.count),    64'd32);
        tick('0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("full_pop_full_n", 64'(s_if.if_full_n), 64'd1);
        check("full_pop_len",    64'(dut_popped.size()), 64'd1);
        if (dut_popped.size() == 1) check("full_pop_word", 64'(dut_popped[0]), 64'd100);
        // Refill, then write+read at full: the write is dropped.
        tick(DW'(200), 1'b1, 1'b0, 1'b0, 1'b1);
        tick(DW'(201), 1'b1, 1'b1, 1'b0, 1'b1);
        check("full_wr_rd_count", 64'(s_if.count), 64'd31);

        // Concurrent push/pop at count=1, then sustained throughput across the wrap.
        tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0, 1'b0, 1'b1);
        w1 = rand_word();
        w2 = rand_word();
        tick(w1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(w2, 1'b1, 1'b1, 1'b0, 1'b1);
        check("c1_count",   64'(s_if.count),      64'd1);
        check("c1_empty_n", 64'(s_if.if_empty_n), 64'd1);
        check("c1_dout",    64'(s_if.if_dout),    64'(w2));
        dut_popped.delete();
        exp_seq.delete();
        exp_seq.push_back(w2);
        for (int k = 0; k < 100; k++) begin
            logic [DW-1:0] d;
            d = rand_word();
            exp_seq.push_back(d);
            tick(d, 1'b1, 1'b1, 1'b0, 1'b1);
            check("c1_no_bubble", 64'(s_if.if_empty_n), 64'd1);
        end
        check("thru_len", 64'(dut_popped.size()), 64'd100);
        for (int k = 0; k < 100 && k < dut_popped.size(); k++) begin
            if (dut_popped[k] !== exp_seq[k]) check($sformatf("thru_word%0d", k), 64'(dut_popped[k]), 64'(exp_seq[k]));
        end
        check("thru_first", 64'(dut_popped.size() > 0 ? dut_popped[0] : '0), 64'(w2));

        // Random traffic: producer-heavy, consumer-heavy, then balanced.
        for (int k = 0; k < 450; k++) begin
            int wp;
            int rp;
            wp = (k < 150) ? 90 : (k < 300) ? 15 : 50;
            rp = (k < 150) ? 20 : (k < 300) ? 85 : 50;
            tick(rand_word(), ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
                 1'($urandom()), 1'b1);
        end

        // Peek toggling with data present changes nothing.
        tick('0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(rand_word(), 1'b1, 1'b0, 1'b0, 1'b1);
        hold = m_q[0];
        for (int k = 0; k < 4; k++) tick('0, 1'b0, 1'b0, (k % 2 == 0), 1'b1);
        check("peek_count", 64'(s_if.count),   64'd3);
        check("peek_dout_hold", 64'(s_if.if_dout), 64'(hold));

        // Drain, then read while empty: underflow set, if_dout holds the last word.
        for (int i = 0; i < 3; i++) tick('0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("unf_pre", 64'(s_if.underflow), 64'd0);
        hold = s_if.if_dout;
        tick('0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("unf_set",       64'(s_if.underflow), 64'd1);
        check("unf_dout_hold", 64'(s_if.if_dout),   64'(hold));

        // Reset in the middle of a transfer drops everything.
        for (int i = 0; i < 7; i++) tick(rand_word(), 1'b1, 1'b0, 1'b0, 1'b1);
        check("mid_count", 64'(s_if.count), 64'd7);
        tick(rand_word(), 1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_rst_count",   64'(s_if.count),      64'd0);
        check("mid_rst_empty_n", 64'(s_if.if_empty_n), 64'd0);
        check("mid_rst_ovf",     64'(s_if.overflow),   64'd0);
        check("mid_rst_unf",     64'(s_if.underflow),  64'd0);
        tick('0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mid_release_full_n", 64'(s_if.if_full_n), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
